axil_mem_slave: RTL and testbench
=================================

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of AW/AR channels.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit memory words.
REQ-003 SHALL have port clk input 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rstn input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port s_axil_awaddr input ADDR_WIDTH, write byte address.
REQ-006 SHALL have port s_axil_awvalid input 1, and s_axil_awready output 1, AW handshake.
REQ-007 SHALL have port s_axil_wdata input 32, and s_axil_wstrb input 4, write data and byte enables.
REQ-008 SHALL have port s_axil_wvalid input 1, and s_axil_wready output 1, W handshake.
REQ-009 SHALL have port s_axil_bresp output 2, s_axil_bvalid output 1, s_axil_bready input 1, write response.
REQ-010 SHALL have port s_axil_araddr input ADDR_WIDTH, s_axil_arvalid input 1, s_axil_arready output 1, read address.
REQ-011 SHALL have port s_axil_rdata output 32, s_axil_rresp output 2, s_axil_rvalid output 1, s_axil_rready input 1, read data.

Function
REQ-012 SHALL act as the AXI4-Lite responder for the CPU wrapper's master port; a handshake occurs on any edge where valid and ready are both 1.
REQ-013 SHALL decode word index = addr[ADDR_WIDTH-1:2]; addr[1:0] SHALL be ignored; index >= DEPTH is out of range.
REQ-014 Write path SHALL latch AW and W independently; awready=1 while no AW held and no response pending; wready=1 while no W held and no response pending.
REQ-015 AW and W SHALL be accepted in either order or in the same cycle; neither channel blocks the other before both are held.
REQ-016 Once both are held, the write SHALL commit on the next edge: each byte lane i with wstrb[i]=1 is updated; lanes with wstrb[i]=0 are unchanged; bvalid rises in that same edge.
REQ-017 Write FSM states SHALL be W_IDLE (collecting AW/W), W_RESP (bvalid=1); W_RESP -> W_IDLE on the B handshake; awready=wready=0 in W_RESP.
REQ-018 bresp SHALL be 2'b00 (OKAY) in range and 2'b10 (SLVERR) out of range; an out-of-range write SHALL NOT modify memory.
REQ-019 bvalid, bresp SHALL stay stable until bready=1.
REQ-020 Read FSM states SHALL be R_IDLE (arready=1), R_DATA (rvalid=1, arready=0); the AR handshake moves R_IDLE -> R_DATA; R_DATA -> R_IDLE on the R handshake.
REQ-021 Read latency SHALL be 1 cycle: rvalid rises on the edge following the AR handshake.
REQ-022 rdata SHALL be the word content at the AR-handshake edge; if a write to the same word commits on that same edge, rdata SHALL return the pre-write value.
REQ-023 Out-of-range read SHALL return rdata=32'h0, rresp=2'b10; in range rresp=2'b00.
REQ-024 rvalid, rdata, rresp SHALL stay stable until rready=1.
REQ-025 Read and write paths SHALL operate concurrently and independently; at most one outstanding transaction per path.

Reset
REQ-026 On rstn=0, asynchronously: both FSMs idle, AW/W held flags cleared, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=0, wready=0, arready=0.
REQ-027 awready, wready, arready SHALL rise on the first edge after rstn deasserts.
REQ-028 Memory contents SHALL NOT be reset; reset mid-transaction SHALL discard held AW/W and pending responses without committing a write.

Verification
REQ-029 AW=0x10 and W=0xDEADBEEF, wstrb=4'hF same cycle, bready=1 -> bvalid next edge, bresp=00; read 0x10 -> rdata=0xDEADBEEF one cycle after AR, rresp=00.
REQ-030 W before AW by 3 cycles (addr 0x20, data 0x11223344, wstrb=4'b0101 over 0xFFFFFFFF) -> wready=0 after W, write commits after AW; read 0x20 -> 0xFF22FF44.
REQ-031 bready=0 for 5 cycles after write -> bvalid/bresp stable, awready=wready=0 throughout; second AW accepted only after the B handshake.
REQ-032 Write to 4*DEPTH (0x1000 at defaults) -> bresp=10, memory unchanged; read same address -> rdata=0, rresp=10.
REQ-033 AR 0x30 and a write commit to 0x30 on the same edge (old 0xA, new 0xB) -> rdata=0xA; subsequent read -> 0xB.
REQ-034 rstn=0 asserted while W held and rvalid=1 with rready=0 -> rvalid=0 immediately, no memory change, readys high one edge after release.

Source files
------------

// File: rtl/axil_mem_slave_if.sv
// axil_mem_slave_if: AXI4-Lite bus bundle between a master and the memory slave
interface axil_mem_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [31:0]           s_axil_wdata;
    logic [3:0]            s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [31:0]           s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );
endinterface

// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite word memory with independent read and write paths
module axil_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input logic             clk,
    input logic             rstn,
    axil_mem_slave_if.slave s
);
    localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         XW     = ADDR_WIDTH - 1;
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic in_range(input logic [ADDR_WIDTH-3:0] idx);
        return {1'b0, idx} < XW'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] widx(input logic [ADDR_WIDTH-3:0] idx);
        return idx[IW-1:0];
    endfunction

    logic [31:0]           mem_q [DEPTH];
    logic                  live_q;
    logic [0:0]            w_state_q, w_state_d;
    logic [0:0]            r_state_q, r_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-3:0] awidx_q, awidx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-3:0] aridx;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, ar_ok;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{s.s_axil_awaddr[1:0], s.s_axil_araddr[1:0]};

    assign s.s_axil_awready = live_q && w_state_q == W_IDLE && !aw_held_q;
    assign s.s_axil_wready  = live_q && w_state_q == W_IDLE && !w_held_q;
    assign s.s_axil_bvalid  = w_state_q == W_RESP;
    assign s.s_axil_bresp   = bresp_q;
    assign s.s_axil_arready = live_q && r_state_q == R_IDLE;
    assign s.s_axil_rvalid  = r_state_q == R_DATA;
    assign s.s_axil_rdata   = rdata_q;
    assign s.s_axil_rresp   = rresp_q;

    assign aw_hs  = s.s_axil_awvalid && s.s_axil_awready;
    assign w_hs   = s.s_axil_wvalid && s.s_axil_wready;
    assign b_hs   = s.s_axil_bvalid && s.s_axil_bready;
    assign ar_hs  = s.s_axil_arvalid && s.s_axil_arready;
    assign r_hs   = s.s_axil_rvalid && s.s_axil_rready;
    assign commit = w_state_q == W_IDLE && aw_held_q && w_held_q;
    assign aridx  = s.s_axil_araddr[ADDR_WIDTH-1:2];
    assign ar_ok  = in_range(aridx);

    // write path: collect AW and W in any order, commit one edge after both are held
    always_comb begin
        aw_held_d = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_held_q);
        w_held_d  = commit ? 1'b0 : (w_hs ? 1'b1 : w_held_q);
        awidx_d   = aw_hs ? s.s_axil_awaddr[ADDR_WIDTH-1:2] : awidx_q;
        wdata_d   = w_hs ? s.s_axil_wdata : wdata_q;
        wstrb_d   = w_hs ? s.s_axil_wstrb : wstrb_q;
        bresp_d   = commit ? (in_range(awidx_q) ? OKAY : SLVERR) : bresp_q;
        w_state_d = commit ? W_RESP : (b_hs ? W_IDLE : w_state_q);
    end

    // read path: capture the pre-write word at the AR edge, hold it until taken
    always_comb begin
        r_state_d = ar_hs ? R_DATA : (r_hs ? R_IDLE : r_state_q);
        rdata_d   = ar_hs ? (ar_ok ? mem_q[widx(aridx)] : 32'h0) : rdata_q;
        rresp_d   = ar_hs ? (ar_ok ? OKAY : SLVERR) : rresp_q;
    end

    // control and response registers; reset drops held requests and pending responses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // storage keeps its contents across reset; only in-range commits write enabled lanes
    always_ff @(posedge clk) begin
        if (commit && in_range(awidx_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem_q[widx(awidx_q)][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axil_mem_slave.sv
// tb_axil_mem_slave: randomized scoreboard bench for the AXI4-Lite memory slave
module tb_axil_mem_slave;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axil_mem_slave_if #(.ADDR_WIDTH(32)) bus();
    axil_mem_slave #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .s(bus));

    int          total = 0;
    int          bad = 0;
    int          b_done = 0;
    int          r_done = 0;
    logic [1:0]  bexp_q [$];
    logic [33:0] rexp_q [$];
    logic [31:0] model [DEPTH];
    bit          b_pend = 0;
    bit          r_pend = 0;
    logic [1:0]  b_last;
    logic [33:0] r_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        if (in_rng(a))
            for (int i = 0; i < 4; i++) if (st[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic logic [33:0] model_rd(input logic [31:0] a);
        return in_rng(a) ? {model[a[11:2]], 2'b00} : {32'h0, 2'b10};
    endfunction

    // monitor: pops expectations on handshakes and checks hold-stability while stalled
    always @(negedge clk) begin
        if (!rstn) begin
            b_pend = 0;
            r_pend = 0;
        end else begin
            if (b_pend && !bus.s_axil_bvalid) begin
                chk("b_held", 64'(bus.s_axil_bvalid), 64'(1));
                b_pend = 0;
            end
            if (bus.s_axil_bvalid) begin
                if (b_pend) chk("b_stable", 64'(bus.s_axil_bresp), 64'(b_last));
                if (bus.s_axil_bready) begin
                    if (bexp_q.size() == 0) chk("b_unexpected", 64'(bexp_q.size()), 64'(1));
                    else chk("bresp", 64'(bus.s_axil_bresp), 64'(bexp_q.pop_front()));
                    b_pend = 0;
                    b_done++;
                end else begin
                    b_pend = 1;
                    b_last = bus.s_axil_bresp;
                end
            end
            if (r_pend && !bus.s_axil_rvalid) begin
                chk("r_held", 64'(bus.s_axil_rvalid), 64'(1));
                r_pend = 0;
            end
            if (bus.s_axil_rvalid) begin
                if (r_pend) chk("r_stable", 64'({bus.s_axil_rdata, bus.s_axil_rresp}), 64'(r_last));
                if (bus.s_axil_rready) begin
                    if (rexp_q.size() == 0) chk("r_unexpected", 64'(rexp_q.size()), 64'(1));
                    else chk("rdata_rresp", 64'({bus.s_axil_rdata, bus.s_axil_rresp}), 64'(rexp_q.pop_front()));
                    r_pend = 0;
                    r_done++;
                end else begin
                    r_pend = 1;
                    r_last = {bus.s_axil_rdata, bus.s_axil_rresp};
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n;
        n = 0;
        bus.s_axil_awaddr = a;
        bus.s_axil_awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.s_axil_awready && n < 100);
        if (!bus.s_axil_awready) chk("aw_timeout", 64'(bus.s_axil_awready), 64'(1));
        tick();
        bus.s_axil_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] st);
        int n;
        n = 0;
        bus.s_axil_wdata = d;
        bus.s_axil_wstrb = st;
        bus.s_axil_wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.s_axil_wready && n < 100);
        if (!bus.s_axil_wready) chk("w_timeout", 64'(bus.s_axil_wready), 64'(1));
        tick();
        bus.s_axil_wvalid = 1'b0;
    endtask

    task automatic wait_b(input int tgt, input int bdly);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_axil_bvalid && n < 100);
        repeat (bdly) begin
            chk("aw_blocked", 64'(bus.s_axil_awready), 64'(0));
            chk("w_blocked", 64'(bus.s_axil_wready), 64'(0));
            @(negedge clk);
        end
        tick();
        bus.s_axil_bready = 1'b1;
        n = 0;
        while (b_done < tgt && n < 100) begin tick(); n++; end
        if (b_done < tgt) chk("b_timeout", 64'(b_done), 64'(tgt));
        bus.s_axil_bready = 1'b0;
    endtask

    // mode 0: AW and W together, 1: W leads by gap cycles, 2: AW leads by gap cycles
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      input int mode, input int gap, input int bdly);
        int tgt;
        tgt = b_done + 1;
        bexp_q.push_back(in_rng(a) ? 2'b00 : 2'b10);
        model_wr(a, d, st);
        if (mode == 0) begin
            fork
                do_aw(a);
                do_w(d, st);
            join
        end else if (mode == 1) begin
            do_w(d, st);
            repeat (gap) begin
                @(negedge clk);
                chk("w_held", 64'(bus.s_axil_wready), 64'(0));
                chk("no_early_b", 64'(bus.s_axil_bvalid), 64'(0));
            end
            tick();
            do_aw(a);
        end else begin
            do_aw(a);
            repeat (gap) begin
                @(negedge clk);
                chk("aw_held", 64'(bus.s_axil_awready), 64'(0));
                chk("no_early_b", 64'(bus.s_axil_bvalid), 64'(0));
            end
            tick();
            do_w(d, st);
        end
        wait_b(tgt, bdly);
    endtask

    task automatic rd(input logic [31:0] a, input int rdly);
        int tgt;
        int n;
        tgt = r_done + 1;
        n = 0;
        rexp_q.push_back(model_rd(a));
        bus.s_axil_araddr = a;
        bus.s_axil_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.s_axil_arready && n < 100);
        if (!bus.s_axil_arready) chk("ar_timeout", 64'(bus.s_axil_arready), 64'(1));
        tick();
        bus.s_axil_arvalid = 1'b0;
        chk("r_latency", 64'(bus.s_axil_rvalid), 64'(1));
        repeat (rdly) tick();
        bus.s_axil_rready = 1'b1;
        n = 0;
        while (r_done < tgt && n < 100) begin tick(); n++; end
        if (r_done < tgt) chk("r_timeout", 64'(r_done), 64'(tgt));
        bus.s_axil_rready = 1'b0;
    endtask

    initial begin
        int bt;
        int rt;
        int n;
        bus.s_axil_awaddr = '0;
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = '0;
        bus.s_axil_wstrb = '0;
        bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = '0;
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready = 1'b0;
        #3;
        chk("rst_awready", 64'(bus.s_axil_awready), 64'(0));
        chk("rst_wready", 64'(bus.s_axil_wready), 64'(0));
        chk("rst_arready", 64'(bus.s_axil_arready), 64'(0));
        chk("rst_bvalid", 64'(bus.s_axil_bvalid), 64'(0));
        chk("rst_rvalid", 64'(bus.s_axil_rvalid), 64'(0));
        chk("rst_resp", 64'({bus.s_axil_bresp, bus.s_axil_rresp}), 64'(0));
        chk("rst_rdata", 64'(bus.s_axil_rdata), 64'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_before_edge", 64'(bus.s_axil_arready), 64'(0));
        tick();
        chk("ready_after_edge", 64'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}), 64'(3'b111));

        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(32'h10, 0);

        wr(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        wr(32'h20, 32'h11223344, 4'b0101, 1, 3, 0);
        rd(32'h20, 2);

        wr(32'h40, 32'h01020304, 4'hF, 0, 0, 5);
        chk("aw_after_b", 64'(bus.s_axil_awready), 64'(1));
        wr(32'h44, 32'h05060708, 4'hF, 2, 2, 0);
        rd(32'h44, 0);

        wr(32'h0, 32'h12345678, 4'hF, 0, 0, 0);
        wr(32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 0, 0, 0);
        rd(32'h0, 0);
        rd(32'(4 * DEPTH), 1);
        rd(32'hFFFFFFFC, 0);

        // read and commit of the same word land on the same edge
        wr(32'h30, 32'hA, 4'hF, 0, 0, 0);
        bt = b_done + 1;
        rt = r_done + 1;
        bexp_q.push_back(2'b00);
        rexp_q.push_back({32'hA, 2'b00});
        model_wr(32'h30, 32'hB, 4'hF);
        bus.s_axil_awaddr = 32'h30;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wdata = 32'hB;
        bus.s_axil_wstrb = 4'hF;
        bus.s_axil_wvalid = 1'b1;
        chk("aw_ready_idle", 64'(bus.s_axil_awready), 64'(1));
        chk("w_ready_idle", 64'(bus.s_axil_wready), 64'(1));
        tick();
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid = 1'b0;
        bus.s_axil_araddr = 32'h30;
        bus.s_axil_arvalid = 1'b1;
        chk("ar_ready_idle", 64'(bus.s_axil_arready), 64'(1));
        tick();
        bus.s_axil_arvalid = 1'b0;
        chk("same_edge_b", 64'(bus.s_axil_bvalid), 64'(1));
        chk("same_edge_r", 64'(bus.s_axil_rvalid), 64'(1));
        bus.s_axil_bready = 1'b1;
        bus.s_axil_rready = 1'b1;
        n = 0;
        while ((b_done < bt || r_done < rt) && n < 100) begin tick(); n++; end
        if (b_done < bt || r_done < rt) chk("same_edge_timeout", 64'({b_done, r_done}), 64'({bt, rt}));
        bus.s_axil_bready = 1'b0;
        bus.s_axil_rready = 1'b0;
        rd(32'h30, 0);

        for (int w = 0; w < 16; w++)
            wr(32'(w * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
        for (int w = 64; w < 80; w++)
            wr(32'(w * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
        repeat (4)
            wr(32'(4 * DEPTH) + ($urandom_range(0, 15) << 2), $urandom, 4'hF, 0, 0, 0);
        for (int w = 0; w < 16; w++) rd(32'(w * 4) + 32'($urandom_range(0, 3)), $urandom_range(0, 2));

        repeat (30) begin
            fork
                wr(32'h100 + ($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3)), $urandom,
                   4'($urandom), $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0)
                    rd(32'(4 * DEPTH) + ($urandom_range(0, 63) << 2), $urandom_range(0, 3));
                else
                    rd(($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3)), $urandom_range(0, 3));
            join
        end
        for (int w = 64; w < 80; w++) rd(32'(w * 4), 0);

        // reset while a W is held and a read response is stalled
        wr(32'h14, 32'h5A5A1234, 4'hF, 0, 0, 0);
        bus.s_axil_araddr = 32'h14;
        bus.s_axil_arvalid = 1'b1;
        bus.s_axil_wdata = 32'hFFFF0000;
        bus.s_axil_wstrb = 4'hF;
        bus.s_axil_wvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_wvalid = 1'b0;
        chk("pre_rst_rvalid", 64'(bus.s_axil_rvalid), 64'(1));
        chk("pre_rst_w_held", 64'(bus.s_axil_wready), 64'(0));
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_rvalid", 64'(bus.s_axil_rvalid), 64'(0));
        chk("async_rst_readys", 64'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}), 64'(0));
        chk("async_rst_rdata", 64'(bus.s_axil_rdata), 64'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}), 64'(0));
        tick();
        chk("rel_ready_after_edge", 64'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}), 64'(3'b111));
        rd(32'h14, 1);
        do_aw(32'h14);
        repeat (3) begin
            @(negedge clk);
            chk("no_commit_after_rst", 64'(bus.s_axil_bvalid), 64'(0));
        end
        tick();
        bt = b_done + 1;
        bexp_q.push_back(2'b00);
        model_wr(32'h14, 32'h0BADCAFE, 4'b1100);
        do_w(32'h0BADCAFE, 4'b1100);
        wait_b(bt, 0);
        rd(32'h14, 0);

        repeat (3) tick();
        chk("bq_drained", 64'(bexp_q.size()), 64'(0));
        chk("rq_drained", 64'(rexp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
